// File: rtl/gg_pkg.sv
// Package for the Givens-generation CORDIC vectoring unit.
// Holds the FSM state type, the default gain-compensation constant, the
// arctangent table used by the optional angle accumulator (GG_ANGLE_EN) and
// the saturation helper shared by the datapath.
package gg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRot,
    StScale,
    StOut
  } gg_state_e;

  // 621/1024, Q1.10: approximates 1/1.64676.
  localparam logic [10:0] K_CONST_DEFAULT = 11'b0_1001101101;

  // atan(2^-i) scaled so that pi == 2^31. Callers take the top DATA_WIDTH
  // bits, which gives pi == 2^(DATA_WIDTH-1) for any DATA_WIDTH <= 32.
  function automatic logic [31:0] atan_lut(input logic [31:0] i);
    logic [31:0] a;
    case (i)
      32'd0:   a = 32'd536870912;
      32'd1:   a = 32'd316933406;
      32'd2:   a = 32'd167458908;
      32'd3:   a = 32'd85004757;
      32'd4:   a = 32'd42667331;
      32'd5:   a = 32'd21354466;
      32'd6:   a = 32'd10679838;
      32'd7:   a = 32'd5340245;
      32'd8:   a = 32'd2670164;
      32'd9:   a = 32'd1335086;
      32'd10:  a = 32'd667544;
      32'd11:  a = 32'd333772;
      // atan(x) ~= x for small x.
      default: a = 32'd683565276 >> i;
    endcase
    return a;
  endfunction

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/gg_microrot.sv
// One combinational CORDIC vectoring micro-rotation with saturation.
// Shift amount is k_i*UNFOLD + STAGE, i.e. this stage's position inside the
// unfolded chain for the current rotate cycle.
// Ports: x_i/y_i current vector, k_i rotate-cycle index, x_o/y_o rotated
// vector, d_o direction bit (1 = clockwise), sat_o either sum saturated.
module gg_microrot
  import gg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned UNFOLD     = 4,
  parameter int unsigned STAGE      = 0,
  parameter int unsigned KW         = 2
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  logic [KW-1:0]         k_i,
  output logic [DATA_WIDTH-1:0] x_o,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic                  d_o,
  output logic                  sat_o
);

  localparam int unsigned MSB = DATA_WIDTH - 1;

  logic [31:0]                  shift;
  logic signed [DATA_WIDTH-1:0] x_sh;
  logic signed [DATA_WIDTH-1:0] y_sh;
  logic signed [DATA_WIDTH:0]   x_sum;
  logic signed [DATA_WIDTH:0]   y_sum;
  logic signed [63:0]           x_ext;
  logic signed [63:0]           y_ext;
  logic signed [63:0]           x_clip;
  logic signed [63:0]           y_clip;

  assign shift = 32'(k_i) * UNFOLD + STAGE;
  assign x_sh  = $signed(x_i) >>> shift;
  assign y_sh  = $signed(y_i) >>> shift;
  // Same signs: rotate clockwise to drive y toward zero.
  assign d_o   = ~(x_i[MSB] ^ y_i[MSB]);

  always_comb begin
    if (d_o) begin
      x_sum = $signed({x_i[MSB], x_i}) + $signed({y_sh[MSB], y_sh});
      y_sum = $signed({y_i[MSB], y_i}) - $signed({x_sh[MSB], x_sh});
    end else begin
      x_sum = $signed({x_i[MSB], x_i}) - $signed({y_sh[MSB], y_sh});
      y_sum = $signed({y_i[MSB], y_i}) + $signed({x_sh[MSB], x_sh});
    end
  end

  assign x_ext  = {{(63 - DATA_WIDTH){x_sum[DATA_WIDTH]}}, x_sum};
  assign y_ext  = {{(63 - DATA_WIDTH){y_sum[DATA_WIDTH]}}, y_sum};
  assign x_clip = sat_clip(x_ext, DATA_WIDTH);
  assign y_clip = sat_clip(y_ext, DATA_WIDTH);
  assign x_o    = x_clip[MSB:0];
  assign y_o    = y_clip[MSB:0];
  assign sat_o  = (x_clip != x_ext) | (y_clip != y_ext);

endmodule

// File: rtl/gg_vectoring_unit.sv
// CORDIC vectoring engine: Givens-generation cell for the QR systolic array.
// Accepts (x, y), pre-rotates left-half-plane inputs, runs ITER micro-rotations
// UNFOLD per clock, then scales by K_CONST.
// Ports: clk/rst (async active-high), in_valid/in_ready + x_in/y_in input
// handshake, out_valid/out_ready + mag_out/res_out/dir_out/qflip_out/sat_flag
// output handshake, busy (not idle).
// Optional: define GG_ANGLE_EN to add the angle accumulator and angle_out.
module gg_vectoring_unit
  import gg_pkg::*;
#(
  parameter int unsigned       DATA_WIDTH = 20,
  parameter int unsigned       ITER       = 12,
  parameter int unsigned       UNFOLD     = 4,
  parameter int unsigned       K_WIDTH    = 11,
  parameter logic [K_WIDTH-1:0] K_CONST   = K_WIDTH'(K_CONST_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] mag_out,
  output logic [DATA_WIDTH-1:0] res_out,
  output logic [ITER-1:0]       dir_out,
  output logic                  qflip_out,
  output logic                  sat_flag,
`ifdef GG_ANGLE_EN
  output logic [DATA_WIDTH-1:0] angle_out,
`endif
  output logic                  busy
);

  localparam int unsigned MSB   = DATA_WIDTH - 1;
  localparam int unsigned N     = ITER / UNFOLD;
  localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);
  localparam int unsigned PW    = DATA_WIDTH + K_WIDTH;

  gg_state_e             state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [ITER-1:0]       dir_q, dir_d;
  logic                  qflip_q, qflip_d;
  logic                  sat_q, sat_d;
  logic                  accept;

  assign in_ready = (state_q == StIdle) | ((state_q == StOut) & out_ready);
  assign accept   = in_valid & in_ready;

  // Pre-rotation by pi for x < 0; -MIN saturates to +MAX.
  logic signed [63:0] xin_ext, yin_ext, xneg, yneg;
  logic               neg_sat;
  assign xin_ext = {{(64 - DATA_WIDTH){x_in[MSB]}}, x_in};
  assign yin_ext = {{(64 - DATA_WIDTH){y_in[MSB]}}, y_in};
  assign xneg    = sat_clip(-xin_ext, DATA_WIDTH);
  assign yneg    = sat_clip(-yin_ext, DATA_WIDTH);
  assign neg_sat = (xneg != -xin_ext) | (yneg != -yin_ext);

  // Unfolded micro-rotation chain.
  logic [DATA_WIDTH-1:0] cx [UNFOLD+1];
  logic [DATA_WIDTH-1:0] cy [UNFOLD+1];
  logic [UNFOLD-1:0]     cd;
  logic [UNFOLD-1:0]     csat;
  assign cx[0] = x_q;
  assign cy[0] = y_q;

  for (genvar s = 0; s < UNFOLD; s++) begin : g_rot
    gg_microrot #(
      .DATA_WIDTH(DATA_WIDTH),
      .UNFOLD    (UNFOLD),
      .STAGE     (s),
      .KW        (KW)
    ) u_rot (
      .x_i  (cx[s]),
      .y_i  (cy[s]),
      .k_i  (k_q),
      .x_o  (cx[s+1]),
      .y_o  (cy[s+1]),
      .d_o  (cd[s]),
      .sat_o(csat[s])
    );
  end

  // Gain compensation: (v * K) >>> (K_WIDTH-1), saturated.
  logic signed [PW-1:0] k_ext, x_prod, y_prod, x_shr, y_shr;
  logic signed [63:0]   xs_ext, ys_ext, xs_clip, ys_clip;
  logic                 scale_sat;
  assign k_ext     = {{DATA_WIDTH{1'b0}}, K_CONST};
  assign x_prod    = $signed({{K_WIDTH{x_q[MSB]}}, x_q}) * k_ext;
  assign y_prod    = $signed({{K_WIDTH{y_q[MSB]}}, y_q}) * k_ext;
  assign x_shr     = x_prod >>> (K_WIDTH - 1);
  assign y_shr     = y_prod >>> (K_WIDTH - 1);
  assign xs_ext    = {{(64 - PW){x_shr[PW-1]}}, x_shr};
  assign ys_ext    = {{(64 - PW){y_shr[PW-1]}}, y_shr};
  assign xs_clip   = sat_clip(xs_ext, DATA_WIDTH);
  assign ys_clip   = sat_clip(ys_ext, DATA_WIDTH);
  assign scale_sat = (xs_clip != xs_ext) | (ys_clip != ys_ext);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRot;
      StRot:   if (k_q == KLast) state_d = StScale;
      StScale: state_d = StOut;
      StOut:   if (out_ready) state_d = accept ? StRot : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    qflip_d = qflip_q;
    sat_d   = sat_q;
    k_d     = k_q;
    if (accept) begin
      x_d     = x_in[MSB] ? xneg[MSB:0] : x_in;
      y_d     = x_in[MSB] ? yneg[MSB:0] : y_in;
      qflip_d = x_in[MSB];
      sat_d   = x_in[MSB] & neg_sat;
      dir_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        StRot: begin
          x_d   = cx[UNFOLD];
          y_d   = cy[UNFOLD];
          sat_d = sat_q | (|csat);
          k_d   = k_q + 1'b1;
          for (int i = 0; i < ITER; i++) begin
            if (32'(k_q) == 32'(i) / UNFOLD) dir_d[i] = cd[32'(i) % UNFOLD];
          end
        end
        StScale: begin
          x_d   = xs_clip[MSB:0];
          y_d   = ys_clip[MSB:0];
          sat_d = sat_q | scale_sat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
      qflip_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      qflip_q <= qflip_d;
      sat_q   <= sat_d;
    end
  end

`ifdef GG_ANGLE_EN
  logic [DATA_WIDTH-1:0] z_q, z_d;

  always_comb begin
    logic [31:0] atan_v;
    atan_v = '0;
    z_d    = z_q;
    if (accept) begin
      // Pre-rotation contributes +pi (wraps modulo 2^DATA_WIDTH).
      z_d = x_in[MSB] ? {1'b1, {(DATA_WIDTH - 1){1'b0}}} : '0;
    end else if (state_q == StRot) begin
      for (int s = 0; s < UNFOLD; s++) begin
        atan_v = atan_lut(32'(k_q) * UNFOLD + 32'(s));
        if (cd[s]) z_d = z_d - atan_v[31 -: DATA_WIDTH];
        else       z_d = z_d + atan_v[31 -: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) z_q <= '0;
    else     z_q <= z_d;
  end

  assign angle_out = z_q;
`endif

  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign mag_out   = x_q;
  assign res_out   = y_q;
  assign dir_out   = dir_q;
  assign qflip_out = qflip_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_gg_vectoring_unit.sv
// Directed self-checking bench for gg_vectoring_unit (default parameters).
module tb_gg_vectoring_unit;

  localparam int unsigned DW = 20;
  localparam int unsigned IT = 12;
  localparam logic [DW-1:0] NomMag = 20'd199735;
  localparam logic [DW-1:0] NomRes = 20'd58;
  localparam logic [IT-1:0] NomDir = 12'h0D3;
  localparam logic [DW-1:0] SatMag = 20'd317951;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic [DW-1:0] y_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] mag_out;
  logic [DW-1:0] res_out;
  logic [IT-1:0] dir_out;
  logic          qflip_out;
  logic          sat_flag;
  logic          busy;
`ifdef GG_ANGLE_EN
  logic [DW-1:0] angle_out;
`endif

  int checks;
  int failures;

  gg_vectoring_unit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mag_out  (mag_out),
    .res_out  (res_out),
    .dir_out  (dir_out),
    .qflip_out(qflip_out),
    .sat_flag (sat_flag),
`ifdef GG_ANGLE_EN
    .angle_out(angle_out),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y);
    x_in = x;
    y_in = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x_in = '0;
    y_in = '0;
    #12;
    checks++;
    if ({in_ready, out_valid, busy, qflip_out, sat_flag} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {in_ready, out_valid, busy, qflip_out, sat_flag});
    end
    checks++;
    if ({mag_out, res_out, dir_out} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {mag_out, res_out, dir_out});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    int lat;
    send(20'd120000, 20'd160000);
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL nom_accept: got busy,in_ready=%b expected 10", {busy, in_ready});
    end
    wait_out(lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL nom_latency: got %0d expected 4", lat);
    end
    checks++;
    if (mag_out !== NomMag) begin
      failures++;
      $display("FAIL nom_mag: got %0d expected %0d", mag_out, NomMag);
    end
    checks++;
    if (res_out !== NomRes) begin
      failures++;
      $display("FAIL nom_res: got %0d expected %0d", $signed(res_out), NomRes);
    end
    checks++;
    if (dir_out !== NomDir) begin
      failures++;
      $display("FAIL nom_dir: got %h expected %h", dir_out, NomDir);
    end
    checks++;
    if ({qflip_out, sat_flag} !== 2'b00) begin
      failures++;
      $display("FAIL nom_flags: got %b expected 00", {qflip_out, sat_flag});
    end
    handshake();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL nom_release: got %b expected 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_lhp();
    int lat;
    send(-20'sd120000, 20'd160000);
    wait_out(lat);
    checks++;
    if ({qflip_out, sat_flag} !== 2'b10) begin
      failures++;
      $display("FAIL lhp_flags: got %b expected 10", {qflip_out, sat_flag});
    end
    checks++;
    if (mag_out < 20'd199000 || mag_out > 20'd201000) begin
      failures++;
      $display("FAIL lhp_mag: got %0d expected 199000..201000", mag_out);
    end
    checks++;
    if ($signed(res_out) < -200 || $signed(res_out) > 200 || dir_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL lhp_res_dir: got res=%0d dir0=%b expected |res|<=200 dir0=0",
               $signed(res_out), dir_out[0]);
    end
    handshake();
  endtask

  task automatic test_saturation();
    int lat;
    send(20'd400000, 20'd400000);
    wait_out(lat);
    checks++;
    if (sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL sat_flag: got %b expected 1", sat_flag);
    end
    checks++;
    if (mag_out !== SatMag) begin
      failures++;
      $display("FAIL sat_mag: got %0d expected %0d", mag_out, SatMag);
    end
    handshake();
  endtask

  task automatic test_zero();
    int lat;
    send(20'd0, 20'd0);
    wait_out(lat);
    checks++;
    if ({mag_out, res_out} !== '0) begin
      failures++;
      $display("FAIL zero_data: got mag=%0d res=%0d expected 0 0", mag_out, res_out);
    end
    checks++;
    if ({dir_out, sat_flag} !== {12'hFFF, 1'b0}) begin
      failures++;
      $display("FAIL zero_dir_sat: got dir=%h sat=%b expected fff 0", dir_out, sat_flag);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    send(20'd120000, 20'd160000);
    wait_out(lat);
    // Competing pair must be ignored while held.
    x_in = 20'd5;
    y_in = 20'd5;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101 || mag_out !== NomMag ||
          res_out !== NomRes || dir_out !== NomDir) begin
        failures++;
        $display("FAIL bp_hold: got ctl=%b mag=%0d dir=%h expected 101 %0d %h",
                 {out_valid, in_ready, busy}, mag_out, dir_out, NomMag, NomDir);
      end
    end
    x_in = '0;
    y_in = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b010) begin
      failures++;
      $display("FAIL bp_same_edge: got %b expected 010", {out_valid, busy, in_ready});
    end
    wait_out(lat);
    checks++;
    if (lat !== 4 || mag_out !== '0 || dir_out !== 12'hFFF) begin
      failures++;
      $display("FAIL bp_next: got lat=%0d mag=%0d dir=%h expected 4 0 fff",
               lat, mag_out, dir_out);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int n;
    int p;
    x_in = 20'd120000;
    y_in = 20'd160000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (mag_out !== NomMag || n !== 5) begin
      failures++;
      $display("FAIL b2b_first: got mag=%0d cycles=%0d expected %0d 5", mag_out, n, NomMag);
    end
    p = 0;
    do begin
      @(posedge clk);
      #1;
      p++;
    end while (out_valid !== 1'b1 && p < 20);
    checks++;
    if (p !== 5) begin
      failures++;
      $display("FAIL b2b_period: got %0d expected 5", p);
    end
    checks++;
    if (mag_out !== NomMag) begin
      failures++;
      $display("FAIL b2b_mag: got %0d expected %0d", mag_out, NomMag);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_idle: got %b expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    send(20'd120000, 20'd160000);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 ||
        {mag_out, res_out, dir_out, qflip_out, sat_flag} !== '0) begin
      failures++;
      $display("FAIL rst_mid: got ctl=%b mag=%0d dir=%h expected 100 0 000",
               {in_ready, out_valid, busy}, mag_out, dir_out);
    end
    @(negedge clk);
    rst = 1'b0;
    send(20'd120000, 20'd160000);
    wait_out(lat);
    checks++;
    if (lat !== 4 || mag_out !== NomMag || dir_out !== NomDir) begin
      failures++;
      $display("FAIL rst_recover: got lat=%0d mag=%0d dir=%h expected 4 %0d %h",
               lat, mag_out, dir_out, NomMag, NomDir);
    end
    handshake();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_nominal();
    test_lhp();
    test_saturation();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
